// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the mux-gate self-test checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_GATES = 7;

  // Bit positions of each gate in the observed / expected / fail vectors.
  localparam int GI_AND  = 0;
  localparam int GI_OR   = 1;
  localparam int GI_NOT  = 2;
  localparam int GI_NAND = 3;
  localparam int GI_NOR  = 4;
  localparam int GI_XOR  = 5;
  localparam int GI_XNOR = 6;

  // Truth tables indexed by {a,b}: bit n holds the expected output for vec==n.
  // "not" is the inversion of a.
  localparam logic [3:0] EXP_TT [NUM_GATES] = '{
    4'b1000,  // and
    4'b1110,  // or
    4'b0011,  // not a
    4'b0111,  // nand
    4'b0001,  // nor
    4'b0110,  // xor
    4'b1001   // xnor
  };

  // Index of the lowest set bit of a gate mask (0 when the mask is empty).
  function automatic logic [2:0] lowest_gate(input logic [NUM_GATES-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int g = NUM_GATES - 1; g >= 0; g--) begin
      if (m[g]) idx = 3'(g);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gate_expect.sv
// Expected seven-gate output vector for a given {a,b} stimulus vector.
// Latency: combinational, zero cycles.
// Backpressure: none (pure lookup).
module gate_expect
  import gate_chk_pkg::*;
(
  input  logic [1:0]           vec,
  output logic [NUM_GATES-1:0] exp_y
);

  // Pick column vec out of every gate's truth table.
  always_comb begin
    exp_y = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      exp_y[g] = EXP_TT[g][vec];
    end
  end

endmodule

// File: rtl/gate_mux_sweep_checker.sv
// Sweeps a/b over all four vectors, checks the gate block outputs, reports results.
// Latency: SETTLE_CYC+1 cycles per vector; done rises NUM_PASSES*4*(SETTLE_CYC+1) edges after start is taken.
// Backpressure: start is ignored while busy; results hold in DONE until the next start. Optional: GATE_CHK_FIRST_FAIL_EN.
module gate_mux_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y_and,
  input  logic             y_or,
  input  logic             y_not,
  input  logic             y_nand,
  input  logic             y_nor,
  input  logic             y_xor,
  input  logic             y_xnor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [6:0]       fail_vec
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,
  output logic [4:0]       first_fail,
  output logic             first_fail_vld
`endif
);

  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [3:0]       SETTLE_END = 4'(SETTLE_CYC - 1);
  localparam logic [2:0]       PASS_END   = 3'(NUM_PASSES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           vec;
  logic [1:0]           vec_inc;
  logic [3:0]           settle_cnt;
  logic [2:0]           pass_cnt;
  logic                 last_vec;
  logic [NUM_GATES-1:0] y_obs;
  logic [NUM_GATES-1:0] exp_y;
  logic [NUM_GATES-1:0] mism;

  gate_expect u_expect (
    .vec   (vec),
    .exp_y (exp_y)
  );

  assign vec_inc  = vec + 2'd1;
  assign last_vec = (vec == 2'd3) && (pass_cnt == PASS_END);
  assign pass     = done && (err_cnt == '0);

  // Gather the gate outputs into one vector and flag mismatches; X/Z counts as a miss.
  always_comb begin
    y_obs          = '0;
    y_obs[GI_AND]  = y_and;
    y_obs[GI_OR]   = y_or;
    y_obs[GI_NOT]  = y_not;
    y_obs[GI_NAND] = y_nand;
    y_obs[GI_NOR]  = y_nor;
    y_obs[GI_XOR]  = y_xor;
    y_obs[GI_XNOR] = y_xnor;
    mism           = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      mism[g] = (y_obs[g] !== exp_y[g]);
    end
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      if (settle_cnt == SETTLE_END) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = last_vec ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register plus the status flags decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == DRIVE) || (state_nxt == SAMPLE);
      done  <= (state_nxt == DONE);
    end
  end

  // Sweep datapath: stimulus, settle/pass counters, error accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= 2'd0;
      settle_cnt <= 4'd0;
      pass_cnt   <= 3'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec        <= 2'd0;
            settle_cnt <= 4'd0;
            pass_cnt   <= 3'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
          end
        end
        DRIVE: begin
          settle_cnt <= settle_cnt + 4'd1;
        end
        SAMPLE: begin
          fail_vec <= fail_vec | mism;
          if ((mism != '0) && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + 1'b1;
          if (!last_vec) begin
            // a/b move only here, on the edge that re-enters DRIVE.
            vec        <= vec_inc;
            a          <= vec_inc[1];
            b          <= vec_inc[0];
            settle_cnt <= 4'd0;
            if (vec == 2'd3) pass_cnt <= pass_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_CHK_FIRST_FAIL_EN
  // Latch where the first mismatch of the sweep happened; later misses leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail     <= 5'd0;
      first_fail_vld <= 1'b0;
    end else if (((state == IDLE) || (state == DONE)) && start) begin
      first_fail     <= 5'd0;
      first_fail_vld <= 1'b0;
    end else if ((state == SAMPLE) && (mism != '0) && !first_fail_vld) begin
      first_fail     <= {vec, lowest_gate(mism)};
      first_fail_vld <= 1'b1;
    end
  end
`endif

endmodule
